chacha_block_engine: RTL and testbench
======================================

# chacha_block_engine

Parametrised ChaCha keystream block generator for the chacha design. Key, nonce and counter are loaded over a narrow input bus. A single iterative quarter-round datapath runs a configurable number of rounds. The 64-byte block is streamed out over a configurable-width output bus, and the block counter auto-increments between blocks.

## Interface
- ROUNDS, 20: total rounds; must be even and in 2..20 (8, 12 and 20 are supported configurations).
- BUS_W, 8: data bus width in bits; one of 8, 16, 32. BPB = BUS_W/8 bytes per beat.
- AUTO_INC, 1: 1 = increment the block counter after the last output beat of each block; 0 = hold it.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_key  in  1  per-beat strobe: write data_in into the key (32 bytes).
- wr_nnc  in  1  per-beat strobe: write data_in into the nonce (12 bytes).
- wr_ctr  in  1  per-beat strobe: write data_in into the block counter (4 bytes).
- data_in  in  BUS_W  write data; the byte in [7:0] is the lowest address.
- start  in  1  pulse: begin computing a block.
- busy  out  1  high in LOAD, ROUND and FINAL.
- blk_ready  out  1  high in READY (block available).
- rd_blk  in  1  per-beat strobe: consume the current output beat.
- data_out  out  BUS_W  current output beat; 0 outside READY.

## Operation
- State matrix follows the IETF layout:
  - words 0–3: constants 61707865, 3320646e, 79622d32, 6b206574
  - words 4–11: key
  - word 12: counter
  - words 13–15: nonce
  - words are little-endian from the byte stream.
- Write pointers: key, nonce and counter each have a byte pointer that advances by BPB per strobe and wraps to 0 at the end of the field (32/12/4 bytes).
  - If BPB does not divide the field length, the excess bytes of the final beat are dropped and the pointer wraps.
- Strobe priority when several are asserted in one cycle: wr_key > wr_nnc > wr_ctr. Only one field is written.
- Writes are ignored in LOAD, ROUND and FINAL. Writes are accepted in IDLE and READY.
  - In READY, writes change the stored inputs only. The block being read is unaffected.
- FSM states: IDLE, LOAD, ROUND, FINAL, READY.
  - IDLE, start=1 → LOAD. start in any other state is ignored.
  - LOAD: copy the input matrix into the working state and save a copy for the feed-forward → ROUND; qr_idx=0.
  - ROUND: one quarter-round per cycle on the working state.
    - qr_idx 0–3 are the columns (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15).
    - qr_idx 4–7 are the diagonals (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14).
    - Repeat ROUNDS/2 times (ROUNDS*4 cycles), then → FINAL.
  - FINAL: 16 mod-2^32 word adds of the working state and the saved input → READY; rd_ptr=0.
  - READY: data_out = output bytes [rd_ptr .. rd_ptr+BPB-1]. On rd_blk, rd_ptr += BPB. On the beat with rd_ptr = 64−BPB, → IDLE and blk_ready falls.
- Quarter-round: a+=b; d^=a; d<<<=16; c+=d; b^=c; b<<<=12; a+=b; d^=a; d<<<=8; c+=d; b^=c; b<<<=7. All arithmetic is 32-bit, carries discarded.
- Counter increment:
  - With AUTO_INC=1, the counter increments on the last read beat.
  - 0xFFFFFFFF wraps to 0 with no flag.
  - A wr_ctr in the same cycle wins over the increment.
- Reset in any state: async return to IDLE with all registers cleared.

## Timing
- Reset values:
  - busy=0, blk_ready=0, data_out=0
  - key, nonce, counter = 0
  - all pointers and qr_idx = 0.
- start sampled in IDLE at edge N gives busy=1 after edge N. blk_ready=1 after edge N+ROUNDS*4+2; for ROUNDS=20 that is 82 cycles.
- data_out is registered-state-driven and valid in the same cycle that blk_ready is high. Each rd_blk beat is accepted on the edge.
- The last beat's rd_blk edge returns the FSM to IDLE. A start on the following cycle is accepted.
- One block read takes 64/BPB rd_blk beats.

## Test plan
- Load the RFC 8439 §2.3.2 vector with BUS_W=8, ROUNDS=20:
  - key bytes 00..1f
  - nonce 00 00 00 09 00 00 00 4a 00 00 00 00
  - counter 01 00 00 00
  - start, then wait 82 cycles, then read 64 beats.
  - Required output: 10 f1 e7 e4 d1 3b 59 15 … a2 50 3c 4e. blk_ready falls after beat 64.
- Same vector with BUS_W=32: 16 beats; first beat e4e7f110, last 4e3c50a2.
- AUTO_INC: after the block above, start again without any writes. The internal counter must be 2, and the output must match a reference model for counter=2. Separately, set counter ff ff ff ff, read a block, and check the next block uses counter 0.
- Hazards:
  - wr_key pulsed during ROUND must be ignored: the output equals the unmodified vector.
  - wr_key and wr_ctr in the same cycle must write the key only.
  - start asserted in READY must be ignored.
- Assert rst mid-ROUND: busy, blk_ready and data_out must be 0 immediately (asynchronously). After release, a fresh all-zero key/nonce/counter block must match the reference model.
- ROUNDS=8 and ROUNDS=12: the latency of ROUNDS*4+2 cycles and the output must match a reference model.

Source files
------------

// File: rtl/chacha_block_engine.sv
// Iterative ChaCha keystream block generator: byte-stream loading of key/nonce/counter,
// one quarter-round per cycle, and beat-wise readout of the 64-byte block.
module chacha_block_engine #(
    parameter int ROUNDS   = 20,
    parameter int BUS_W    = 8,
    parameter int AUTO_INC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_key,
    input  logic             wr_nnc,
    input  logic             wr_ctr,
    input  logic [BUS_W-1:0] data_in,
    input  logic             start,
    output logic             busy,
    output logic             blk_ready,
    input  logic             rd_blk,
    output logic [BUS_W-1:0] data_out
);

    localparam int BPB   = BUS_W / 8;
    localparam int STEPS = ROUNDS * 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_READY = 3'd4
    } state_t;

    state_t      state_q;
    logic [6:0]  step_q;
    logic [5:0]  rd_ptr_q;
    logic [31:0] work_q [16];
    logic [31:0] orig_q [16];

    logic [7:0]  key_q [32];
    logic [7:0]  key_d [32];
    logic [7:0]  nnc_q [12];
    logic [7:0]  nnc_d [12];
    logic [7:0]  ctr_q [4];
    logic [7:0]  ctr_d [4];
    logic [5:0]  key_ptr_q, key_ptr_d;
    logic [3:0]  nnc_ptr_q, nnc_ptr_d;
    logic [1:0]  ctr_ptr_q, ctr_ptr_d;

    logic [31:0]  in_mat_s    [16];
    logic [31:0]  work_qr_s   [16];
    logic [31:0]  ctr_word_s;
    logic [3:0]   qa_s, qb_s, qc_s, qd_s;
    logic [127:0] qr_out_s;
    logic         wr_ok_s;
    logic         last_beat_s;

    function automatic logic [31:0] rotl32(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] quarter_round(input logic [127:0] abcd);
        logic [31:0] a, b, c, d;
        a = abcd[127:96];
        b = abcd[95:64];
        c = abcd[63:32];
        d = abcd[31:0];
        a = a + b; d = rotl32(d ^ a, 16);
        c = c + d; b = rotl32(b ^ c, 12);
        a = a + b; d = rotl32(d ^ a, 8);
        c = c + d; b = rotl32(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    assign ctr_word_s  = {ctr_q[3], ctr_q[2], ctr_q[1], ctr_q[0]};
    assign wr_ok_s     = (state_q == S_IDLE) || (state_q == S_READY);
    assign last_beat_s = (state_q == S_READY) && rd_blk && (rd_ptr_q == 6'(64 - BPB));
    assign busy        = (state_q == S_LOAD) || (state_q == S_ROUND) || (state_q == S_FINAL);
    assign blk_ready   = (state_q == S_READY);

    // Assemble the IETF input matrix from the stored key, counter and nonce
    always_comb begin
        in_mat_s[0] = 32'h61707865;
        in_mat_s[1] = 32'h3320646e;
        in_mat_s[2] = 32'h79622d32;
        in_mat_s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) begin
            in_mat_s[4 + i] = {key_q[4*i+3], key_q[4*i+2], key_q[4*i+1], key_q[4*i]};
        end
        in_mat_s[12] = ctr_word_s;
        for (int i = 0; i < 3; i++) begin
            in_mat_s[13 + i] = {nnc_q[4*i+3], nnc_q[4*i+2], nnc_q[4*i+1], nnc_q[4*i]};
        end
    end

    // Column/diagonal word selection and the single quarter-round datapath
    always_comb begin
        case (step_q[2:0])
            3'd0:    {qa_s, qb_s, qc_s, qd_s} = {4'd0, 4'd4, 4'd8,  4'd12};
            3'd1:    {qa_s, qb_s, qc_s, qd_s} = {4'd1, 4'd5, 4'd9,  4'd13};
            3'd2:    {qa_s, qb_s, qc_s, qd_s} = {4'd2, 4'd6, 4'd10, 4'd14};
            3'd3:    {qa_s, qb_s, qc_s, qd_s} = {4'd3, 4'd7, 4'd11, 4'd15};
            3'd4:    {qa_s, qb_s, qc_s, qd_s} = {4'd0, 4'd5, 4'd10, 4'd15};
            3'd5:    {qa_s, qb_s, qc_s, qd_s} = {4'd1, 4'd6, 4'd11, 4'd12};
            3'd6:    {qa_s, qb_s, qc_s, qd_s} = {4'd2, 4'd7, 4'd8,  4'd13};
            3'd7:    {qa_s, qb_s, qc_s, qd_s} = {4'd3, 4'd4, 4'd9,  4'd14};
            default: {qa_s, qb_s, qc_s, qd_s} = {4'd0, 4'd4, 4'd8,  4'd12};
        endcase
        qr_out_s = quarter_round({work_q[qa_s], work_q[qb_s], work_q[qc_s], work_q[qd_s]});
        work_qr_s = work_q;
        work_qr_s[qa_s] = qr_out_s[127:96];
        work_qr_s[qb_s] = qr_out_s[95:64];
        work_qr_s[qc_s] = qr_out_s[63:32];
        work_qr_s[qd_s] = qr_out_s[31:0];
    end

    // Input field writes with wrapping byte pointers, then counter auto-increment
    always_comb begin
        key_d     = key_q;
        nnc_d     = nnc_q;
        ctr_d     = ctr_q;
        key_ptr_d = key_ptr_q;
        nnc_ptr_d = nnc_ptr_q;
        ctr_ptr_d = ctr_ptr_q;
        if (wr_ok_s && wr_key) begin
            for (int j = 0; j < BPB; j++) begin
                if (int'(key_ptr_q) + j < 32) begin
                    key_d[5'(int'(key_ptr_q) + j)] = data_in[8*j +: 8];
                end else begin
                    key_d[5'(int'(key_ptr_q))] = key_d[5'(int'(key_ptr_q))];
                end
            end
            key_ptr_d = (int'(key_ptr_q) + BPB >= 32) ? 6'd0 : 6'(int'(key_ptr_q) + BPB);
        end else if (wr_ok_s && wr_nnc) begin
            for (int j = 0; j < BPB; j++) begin
                if (int'(nnc_ptr_q) + j < 12) begin
                    nnc_d[4'(int'(nnc_ptr_q) + j)] = data_in[8*j +: 8];
                end else begin
                    nnc_d[nnc_ptr_q] = nnc_d[nnc_ptr_q];
                end
            end
            nnc_ptr_d = (int'(nnc_ptr_q) + BPB >= 12) ? 4'd0 : 4'(int'(nnc_ptr_q) + BPB);
        end else if (wr_ok_s && wr_ctr) begin
            for (int j = 0; j < BPB; j++) begin
                if (int'(ctr_ptr_q) + j < 4) begin
                    ctr_d[2'(int'(ctr_ptr_q) + j)] = data_in[8*j +: 8];
                end else begin
                    ctr_d[ctr_ptr_q] = ctr_d[ctr_ptr_q];
                end
            end
            ctr_ptr_d = (int'(ctr_ptr_q) + BPB >= 4) ? 2'd0 : 2'(int'(ctr_ptr_q) + BPB);
        end else if ((AUTO_INC == 1) && last_beat_s) begin
            {ctr_d[3], ctr_d[2], ctr_d[1], ctr_d[0]} = ctr_word_s + 32'd1;
        end else begin
            ctr_ptr_d = ctr_ptr_q;
        end
    end

    // Output beat selection from the finished block
    always_comb begin
        logic [5:0] bidx;
        bidx     = 6'd0;
        data_out = {BUS_W{1'b0}};
        if (state_q == S_READY) begin
            for (int j = 0; j < BPB; j++) begin
                bidx = rd_ptr_q + 6'(j);
                data_out[8*j +: 8] = work_q[bidx[5:2]][{bidx[1:0], 3'b000} +: 8];
            end
        end else begin
            data_out = {BUS_W{1'b0}};
        end
    end

    // Stored key, nonce, counter and their write pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) key_q[i] <= 8'd0;
            for (int i = 0; i < 12; i++) nnc_q[i] <= 8'd0;
            for (int i = 0; i < 4; i++)  ctr_q[i] <= 8'd0;
            key_ptr_q <= 6'd0;
            nnc_ptr_q <= 4'd0;
            ctr_ptr_q <= 2'd0;
        end else begin
            key_q     <= key_d;
            nnc_q     <= nnc_d;
            ctr_q     <= ctr_d;
            key_ptr_q <= key_ptr_d;
            nnc_ptr_q <= nnc_ptr_d;
            ctr_ptr_q <= ctr_ptr_d;
        end
    end

    // Block FSM: load, iterate quarter-rounds, feed-forward, stream out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            step_q   <= 7'd0;
            rd_ptr_q <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                work_q[i] <= 32'd0;
                orig_q[i] <= 32'd0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_LOAD;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    work_q  <= in_mat_s;
                    orig_q  <= in_mat_s;
                    step_q  <= 7'd0;
                    state_q <= S_ROUND;
                end
                S_ROUND: begin
                    work_q <= work_qr_s;
                    step_q <= step_q + 7'd1;
                    if (step_q == 7'(STEPS - 1)) begin
                        state_q <= S_FINAL;
                    end else begin
                        state_q <= S_ROUND;
                    end
                end
                S_FINAL: begin
                    for (int i = 0; i < 16; i++) begin
                        work_q[i] <= work_q[i] + orig_q[i];
                    end
                    rd_ptr_q <= 6'd0;
                    state_q  <= S_READY;
                end
                S_READY: begin
                    if (rd_blk) begin
                        rd_ptr_q <= rd_ptr_q + 6'(BPB);
                        if (last_beat_s) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_READY;
                        end
                    end else begin
                        state_q <= S_READY;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chacha_block_engine.sv
// Self-checking bench: four engine configurations against a behavioural ChaCha model.
module tb_chacha_block_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  wr_key_v, wr_nnc_v, wr_ctr_v, start_v, rd_blk_v;
    logic [31:0] din_a [4];
    wire  [3:0]  busy_v, rdy_v;
    wire  [7:0]  do0;
    wire  [31:0] do1;
    wire  [15:0] do2;
    wire  [7:0]  do3;

    logic [7:0]  key_m [4][32];
    logic [7:0]  nnc_m [4][12];
    logic [31:0] ctr_m [4];
    logic [7:0]  exp_b [64];
    logic [31:0] mx [16];
    logic [31:0] last_obs;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    chacha_block_engine #(.ROUNDS(20), .BUS_W(8), .AUTO_INC(1)) u_d0 (
        .clk(clk), .rst(rst), .wr_key(wr_key_v[0]), .wr_nnc(wr_nnc_v[0]), .wr_ctr(wr_ctr_v[0]),
        .data_in(din_a[0][7:0]), .start(start_v[0]), .busy(busy_v[0]), .blk_ready(rdy_v[0]),
        .rd_blk(rd_blk_v[0]), .data_out(do0));
    chacha_block_engine #(.ROUNDS(20), .BUS_W(32), .AUTO_INC(1)) u_d1 (
        .clk(clk), .rst(rst), .wr_key(wr_key_v[1]), .wr_nnc(wr_nnc_v[1]), .wr_ctr(wr_ctr_v[1]),
        .data_in(din_a[1]), .start(start_v[1]), .busy(busy_v[1]), .blk_ready(rdy_v[1]),
        .rd_blk(rd_blk_v[1]), .data_out(do1));
    chacha_block_engine #(.ROUNDS(8), .BUS_W(16), .AUTO_INC(1)) u_d2 (
        .clk(clk), .rst(rst), .wr_key(wr_key_v[2]), .wr_nnc(wr_nnc_v[2]), .wr_ctr(wr_ctr_v[2]),
        .data_in(din_a[2][15:0]), .start(start_v[2]), .busy(busy_v[2]), .blk_ready(rdy_v[2]),
        .rd_blk(rd_blk_v[2]), .data_out(do2));
    chacha_block_engine #(.ROUNDS(12), .BUS_W(8), .AUTO_INC(1)) u_d3 (
        .clk(clk), .rst(rst), .wr_key(wr_key_v[3]), .wr_nnc(wr_nnc_v[3]), .wr_ctr(wr_ctr_v[3]),
        .data_in(din_a[3][7:0]), .start(start_v[3]), .busy(busy_v[3]), .blk_ready(rdy_v[3]),
        .rd_blk(rd_blk_v[3]), .data_out(do3));

    function automatic int bpb_of(input int k);
        case (k)
            1:       return 4;
            2:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int rounds_of(input int k);
        case (k)
            2:       return 8;
            3:       return 12;
            default: return 20;
        endcase
    endfunction

    function automatic logic [31:0] dout_of(input int k);
        case (k)
            0:       return {24'd0, do0};
            1:       return do1;
            2:       return {16'd0, do2};
            default: return {24'd0, do3};
        endcase
    endfunction

    function automatic logic [7:0] fbyte(input int k, input int fld, input int i);
        if (fld == 0)      return key_m[k][i];
        else if (fld == 1) return nnc_m[k][i];
        else               return ctr_m[k][8*i +: 8];
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] exp_beat(input int k, input int p);
        logic [31:0] v;
        v = 32'd0;
        for (int j = 0; j < bpb_of(k); j++) v[8*j +: 8] = exp_b[p + j];
        return v;
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic qr_m(input int a, input int b, input int c, input int d);
        mx[a] = mx[a] + mx[b]; mx[d] = rotl(mx[d] ^ mx[a], 16);
        mx[c] = mx[c] + mx[d]; mx[b] = rotl(mx[b] ^ mx[c], 12);
        mx[a] = mx[a] + mx[b]; mx[d] = rotl(mx[d] ^ mx[a], 8);
        mx[c] = mx[c] + mx[d]; mx[b] = rotl(mx[b] ^ mx[c], 7);
    endtask

    // Reference block for the inputs currently recorded for instance k
    task automatic ref_block(input int k);
        logic [31:0] s [16];
        logic [31:0] w;
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++)
            s[4+i] = {key_m[k][4*i+3], key_m[k][4*i+2], key_m[k][4*i+1], key_m[k][4*i]};
        s[12] = ctr_m[k];
        for (int i = 0; i < 3; i++)
            s[13+i] = {nnc_m[k][4*i+3], nnc_m[k][4*i+2], nnc_m[k][4*i+1], nnc_m[k][4*i]};
        for (int i = 0; i < 16; i++) mx[i] = s[i];
        for (int r = 0; r < rounds_of(k); r += 2) begin
            qr_m(0, 4, 8, 12); qr_m(1, 5, 9, 13); qr_m(2, 6, 10, 14); qr_m(3, 7, 11, 15);
            qr_m(0, 5, 10, 15); qr_m(1, 6, 11, 12); qr_m(2, 7, 8, 13); qr_m(3, 4, 9, 14);
        end
        for (int i = 0; i < 16; i++) begin
            w = mx[i] + s[i];
            for (int b = 0; b < 4; b++) exp_b[4*i+b] = w[8*b +: 8];
        end
    endtask

    task automatic write_field(input int k, input int fld, input bit also_ctr);
        int len;
        len = (fld == 0) ? 32 : ((fld == 1) ? 12 : 4);
        for (int p = 0; p < len; p += bpb_of(k)) begin
            din_a[k] = 32'd0;
            for (int j = 0; j < bpb_of(k); j++) din_a[k][8*j +: 8] = fbyte(k, fld, p + j);
            if (fld == 0)      wr_key_v[k] = 1'b1;
            else if (fld == 1) wr_nnc_v[k] = 1'b1;
            else               wr_ctr_v[k] = 1'b1;
            if (also_ctr) wr_ctr_v[k] = 1'b1;
            tick();
            wr_key_v[k] = 1'b0; wr_nnc_v[k] = 1'b0; wr_ctr_v[k] = 1'b0;
        end
    endtask

    task automatic load_all(input int k);
        write_field(k, 0, 1'b0);
        write_field(k, 1, 1'b0);
        write_field(k, 2, 1'b0);
    endtask

    task automatic rand_fields(input int k);
        for (int i = 0; i < 32; i++) key_m[k][i] = 8'($urandom);
        for (int i = 0; i < 12; i++) nnc_m[k][i] = 8'($urandom);
        ctr_m[k] = $urandom;
    endtask

    task automatic set_rfc(input int k);
        for (int i = 0; i < 32; i++) key_m[k][i] = 8'(i);
        for (int i = 0; i < 12; i++) nnc_m[k][i] = 8'd0;
        nnc_m[k][3] = 8'h09;
        nnc_m[k][7] = 8'h4a;
        ctr_m[k] = 32'd1;
    endtask

    // Start a block; optionally hammer wr_key while the engine is computing
    task automatic run_block(input int k, input bit hazard);
        int lat;
        start_v[k] = 1'b1;
        tick();
        start_v[k] = 1'b0;
        chk_eq("busy_after_start", {31'd0, busy_v[k]}, 32'd1);
        lat = 0;
        while (rdy_v[k] !== 1'b1 && lat < 300) begin
            if (hazard) begin
                din_a[k] = $urandom;
                wr_key_v[k] = 1'b1;
            end
            tick();
            wr_key_v[k] = 1'b0;
            lat++;
        end
        chk_eq("latency", 32'(lat), 32'(rounds_of(k) * 4 + 2));
    endtask

    task automatic read_block(input int k);
        for (int p = 0; p < 64; p += bpb_of(k)) begin
            chk_eq("beat_ready", {31'd0, rdy_v[k]}, 32'd1);
            chk_eq("beat_data", dout_of(k), exp_beat(k, p));
            last_obs = dout_of(k);
            rd_blk_v[k] = 1'b1;
            tick();
            rd_blk_v[k] = 1'b0;
        end
        chk_eq("ready_fall", {31'd0, rdy_v[k]}, 32'd0);
        chk_eq("busy_idle", {31'd0, busy_v[k]}, 32'd0);
        chk_eq("dout_idle", dout_of(k), 32'd0);
        ctr_m[k] = ctr_m[k] + 32'd1;
    endtask

    task automatic do_block(input int k, input bit hazard);
        run_block(k, hazard);
        ref_block(k);
        read_block(k);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        wr_key_v = 4'd0; wr_nnc_v = 4'd0; wr_ctr_v = 4'd0; start_v = 4'd0; rd_blk_v = 4'd0;
        for (int k = 0; k < 4; k++) begin
            din_a[k] = 32'd0;
            for (int i = 0; i < 32; i++) key_m[k][i] = 8'd0;
            for (int i = 0; i < 12; i++) nnc_m[k][i] = 8'd0;
            ctr_m[k] = 32'd0;
        end
        repeat (3) tick();
        for (int k = 0; k < 4; k++) begin
            chk_eq("reset_busy", {31'd0, busy_v[k]}, 32'd0);
            chk_eq("reset_ready", {31'd0, rdy_v[k]}, 32'd0);
            chk_eq("reset_dout", dout_of(k), 32'd0);
        end
        rst = 1'b0;
        tick();

        // RFC 8439 block on the byte-wide engine; start in READY must be ignored
        set_rfc(0);
        load_all(0);
        run_block(0, 1'b0);
        ref_block(0);
        chk_eq("rfc_model_w0", {exp_b[3], exp_b[2], exp_b[1], exp_b[0]}, 32'he4e7f110);
        chk_eq("rfc_model_w15", {exp_b[63], exp_b[62], exp_b[61], exp_b[60]}, 32'h4e3c50a2);
        chk_eq("rfc_first_byte", dout_of(0), 32'h10);
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        chk_eq("start_in_ready_rdy", {31'd0, rdy_v[0]}, 32'd1);
        chk_eq("start_in_ready_busy", {31'd0, busy_v[0]}, 32'd0);
        read_block(0);
        chk_eq("rfc_last_byte", last_obs, 32'h4e);
        do_block(0, 1'b0);

        // Same vector on the 32-bit engine, then counter wrap
        set_rfc(1);
        load_all(1);
        run_block(1, 1'b0);
        ref_block(1);
        chk_eq("bus32_first", dout_of(1), 32'he4e7f110);
        read_block(1);
        chk_eq("bus32_last", last_obs, 32'h4e3c50a2);
        ctr_m[1] = 32'hffffffff;
        write_field(1, 2, 1'b0);
        do_block(1, 1'b0);
        do_block(1, 1'b0);

        // wr_key during computation is ignored; wr_key+wr_ctr writes only the key
        set_rfc(0);
        write_field(0, 2, 1'b0);
        do_block(0, 1'b1);
        for (int i = 0; i < 32; i++) key_m[0][i] = 8'($urandom);
        write_field(0, 0, 1'b1);
        do_block(0, 1'b0);

        // Writes in READY affect only the next block
        rand_fields(2);
        load_all(2);
        run_block(2, 1'b0);
        ref_block(2);
        for (int i = 0; i < 32; i++) key_m[2][i] = 8'($urandom);
        write_field(2, 0, 1'b0);
        read_block(2);
        do_block(2, 1'b0);

        // Randomized blocks on the 8- and 12-round engines
        for (int it = 0; it < 3; it++) begin
            for (int k = 2; k < 4; k++) begin
                rand_fields(k);
                load_all(k);
                do_block(k, 1'b0);
            end
        end

        // Asynchronous reset in the middle of ROUND
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        repeat (10) tick();
        chk_eq("busy_mid_round", {31'd0, busy_v[0]}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk_eq("async_rst_busy", {31'd0, busy_v[0]}, 32'd0);
        chk_eq("async_rst_ready", {31'd0, rdy_v[0]}, 32'd0);
        chk_eq("async_rst_dout", dout_of(0), 32'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 32; i++) key_m[k][i] = 8'd0;
            for (int i = 0; i < 12; i++) nnc_m[k][i] = 8'd0;
            ctr_m[k] = 32'd0;
        end
        tick();
        do_block(0, 1'b0);
        chk_eq("zero_model_w0", {exp_b[3], exp_b[2], exp_b[1], exp_b[0]}, 32'hade0b876);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
